// File: rtl/array2d_pkg.sv
// Shared sizing and addressing helpers for the 2-D register array and its
// index checkers.
package array2d_pkg;

   function automatic int span(input int lo, input int hi);
      return hi - lo + 1;
   endfunction

   function automatic int depth_of(input int row_lo, input int row_hi,
                                   input int col_lo, input int col_hi);
      return span(row_lo, row_hi) * span(col_lo, col_hi);
   endfunction

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic int bit_sel_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

   // Row-major flattening, relative to the lowest legal row and column.
   function automatic int flat_addr(input int row, input int col,
                                    input int row_lo, input int col_lo,
                                    input int cols);
      return (row - row_lo) * cols + (col - col_lo);
   endfunction

endpackage

// File: rtl/array2d_idx_check.sv
// Combinational bounds check and flat-address generation for one row/column
// index pair; the address is forced to 0 whenever the pair is out of range.
module array2d_idx_check
   import array2d_pkg::*;
#(
   parameter int ROW_LO = 0,
   parameter int ROW_HI = 3,
   parameter int COL_LO = 1,
   parameter int COL_HI = 2,
   parameter int IDX_W  = 8,
   parameter int AW     = 3
) (
   input  logic [IDX_W-1:0] row,
   input  logic [IDX_W-1:0] col,
   output logic             in_range,
   output logic [AW-1:0]    addr
);

   localparam int COLS = span(COL_LO, COL_HI);

   int row_i;
   int col_i;

   always_comb begin
      row_i    = int'(row);
      col_i    = int'(col);
      in_range = (row_i >= ROW_LO) && (row_i <= ROW_HI) &&
                 (col_i >= COL_LO) && (col_i <= COL_HI);
      addr     = '0;
      if (in_range) begin
         addr = AW'(flat_addr(row_i, col_i, ROW_LO, COL_LO, COLS));
      end
   end

endmodule

// File: rtl/array2d_watch.sv
// Bounds-checked 2-D register array with a registered read port and a
// saturating transition counter on one selectable element bit.
module array2d_watch
   import array2d_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int ROW_LO = 0,
   parameter int ROW_HI = 3,
   parameter int COL_LO = 1,
   parameter int COL_HI = 2,
   parameter int IDX_W  = 8,
   parameter int CNT_W  = 8,
   localparam int BW    = bit_sel_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_row,
   input  logic [IDX_W-1:0] wr_col,
   input  logic [WIDTH-1:0] wr_data,
   output logic             wr_oob,
   input  logic             rd_en,
   input  logic [IDX_W-1:0] rd_row,
   input  logic [IDX_W-1:0] rd_col,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             rd_oob,
   input  logic [IDX_W-1:0] watch_row,
   input  logic [IDX_W-1:0] watch_col,
   input  logic [BW-1:0]    watch_bit,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] watch_cnt,
   output logic             watch_pulse
);

   localparam int DEPTH = depth_of(ROW_LO, ROW_HI, COL_LO, COL_HI);
   localparam int AW    = addr_width(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [WIDTH-1:0] mem [DEPTH];

   logic          wr_in_range;
   logic [AW-1:0] wr_addr;
   logic          rd_in_range;
   logic [AW-1:0] rd_addr;
   logic          watch_in_range;
   logic [AW-1:0] watch_addr;

   logic             wr_hit;
   logic [WIDTH-1:0] wr_old;
   logic             watch_hit;

   array2d_idx_check #(
      .ROW_LO(ROW_LO), .ROW_HI(ROW_HI), .COL_LO(COL_LO), .COL_HI(COL_HI),
      .IDX_W(IDX_W), .AW(AW)
   ) u_wr_idx (
      .row(wr_row), .col(wr_col), .in_range(wr_in_range), .addr(wr_addr)
   );

   array2d_idx_check #(
      .ROW_LO(ROW_LO), .ROW_HI(ROW_HI), .COL_LO(COL_LO), .COL_HI(COL_HI),
      .IDX_W(IDX_W), .AW(AW)
   ) u_rd_idx (
      .row(rd_row), .col(rd_col), .in_range(rd_in_range), .addr(rd_addr)
   );

   array2d_idx_check #(
      .ROW_LO(ROW_LO), .ROW_HI(ROW_HI), .COL_LO(COL_LO), .COL_HI(COL_HI),
      .IDX_W(IDX_W), .AW(AW)
   ) u_watch_idx (
      .row(watch_row), .col(watch_col), .in_range(watch_in_range), .addr(watch_addr)
   );

   // A transition is a real in-range write to the watched element whose
   // watched bit differs from the value currently stored there.
   always_comb begin
      wr_hit    = wr_en && wr_in_range;
      wr_old    = mem[wr_addr];
      watch_hit = wr_hit && watch_in_range && (wr_addr == watch_addr) &&
                  (wr_data[watch_bit] != wr_old[watch_bit]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_oob <= 1'b0;
      end else begin
         if (wr_hit) begin
            mem[wr_addr] <= wr_data;
         end
         wr_oob <= wr_en && !wr_in_range;
      end
   end

   // Read-first: the array is sampled before any same-edge write lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_oob   <= 1'b0;
      end else if (rd_en) begin
         rd_valid <= 1'b1;
         rd_oob   <= !rd_in_range;
         rd_data  <= rd_in_range ? mem[rd_addr] : '0;
      end else begin
         rd_valid <= 1'b0;
         rd_oob   <= 1'b0;
      end
   end

   // Clear wins over increment, but the pulse still reports the transition.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         watch_cnt   <= '0;
         watch_pulse <= 1'b0;
      end else begin
         watch_pulse <= watch_hit;
         if (cnt_clr) begin
            watch_cnt <= '0;
         end else if (watch_hit && (watch_cnt != CNT_MAX)) begin
            watch_cnt <= watch_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_array2d_watch.sv
// Directed bench for array2d_watch: a vector table for single-cycle
// behaviour plus hand sequences for watch, saturation and reset corners.
module tb_array2d_watch;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr_en;
   logic [7:0] wr_row, wr_col, wr_data;
   logic       rd_en;
   logic [7:0] rd_row, rd_col;
   logic [7:0] watch_row, watch_col;
   logic [2:0] watch_bit;
   logic       cnt_clr;

   logic       wr_oob, rd_valid, rd_oob, watch_pulse;
   logic [7:0] rd_data, watch_cnt;

   logic       s_wr_oob, s_rd_valid, s_rd_oob, s_watch_pulse;
   logic [7:0] s_rd_data;
   logic [1:0] s_watch_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       wr_en;
      logic [7:0] wr_row, wr_col, wr_data;
      logic       rd_en;
      logic [7:0] rd_row, rd_col;
      logic       x_wr_oob, x_rd_valid, x_rd_oob;
      logic [7:0] x_rd_data;
      int         x_cnt;
      logic       x_pulse;
   } vec_t;

   vec_t vecs[$];

   always #5 clk = ~clk;

   array2d_watch dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_oob(wr_oob),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_oob(rd_oob),
      .watch_row(watch_row), .watch_col(watch_col), .watch_bit(watch_bit),
      .cnt_clr(cnt_clr), .watch_cnt(watch_cnt), .watch_pulse(watch_pulse)
   );

   array2d_watch #(.CNT_W(2)) u_sat (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data), .wr_oob(s_wr_oob),
      .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
      .rd_data(s_rd_data), .rd_valid(s_rd_valid), .rd_oob(s_rd_oob),
      .watch_row(watch_row), .watch_col(watch_col), .watch_bit(watch_bit),
      .cnt_clr(cnt_clr), .watch_cnt(s_watch_cnt), .watch_pulse(s_watch_pulse)
   );

   function automatic vec_t mk(input logic we, input int wr, input int wc, input int wd,
                               input logic re, input int rr, input int rc,
                               input logic xwo, input logic xrv, input logic xro,
                               input int xrd, input int xc, input logic xp);
      vec_t v;
      v.wr_en = we;  v.wr_row = 8'(wr); v.wr_col = 8'(wc); v.wr_data = 8'(wd);
      v.rd_en = re;  v.rd_row = 8'(rr); v.rd_col = 8'(rc);
      v.x_wr_oob = xwo; v.x_rd_valid = xrv; v.x_rd_oob = xro;
      v.x_rd_data = 8'(xrd); v.x_cnt = xc; v.x_pulse = xp;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      wr_en = v.wr_en; wr_row = v.wr_row; wr_col = v.wr_col; wr_data = v.wr_data;
      rd_en = v.rd_en; rd_row = v.rd_row; rd_col = v.rd_col;
      tick();
   endtask

   task automatic idleInputs();
      wr_en = 1'b0; rd_en = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic readCheck(input string name, input int r, input int c, input int exp, input int exp_cnt);
      wr_en = 1'b0; rd_en = 1'b1; rd_row = 8'(r); rd_col = 8'(c);
      tick();
      checkOutput({name, " valid"}, 32'(rd_valid), 32'd1);
      checkOutput({name, " data"}, 32'(rd_data), 32'(exp));
      checkOutput({name, " oob"}, 32'(rd_oob), 32'd0);
      checkOutput({name, " cnt"}, 32'(watch_cnt), 32'(exp_cnt));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int sat_pulses;
      int r_exp [4][2];

      rst_n = 1'b0;
      wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
      rd_en = 1'b0; rd_row = '0; rd_col = '0;
      watch_row = 8'd2; watch_col = 8'd2; watch_bit = 3'd3; cnt_clr = 1'b0;
      tick();
      tick();
      checkOutput("reset rd_data", 32'(rd_data), 32'd0);
      checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("reset rd_oob", 32'(rd_oob), 32'd0);
      checkOutput("reset wr_oob", 32'(wr_oob), 32'd0);
      checkOutput("reset watch_cnt", 32'(watch_cnt), 32'd0);
      checkOutput("reset watch_pulse", 32'(watch_pulse), 32'd0);
      rst_n = 1'b1;

      r_exp = '{'{0, 0}, '{0, 0}, '{7, 8}, '{0, 8}};
      vecs.push_back(mk(1, 2, 1, 7,    0, 0, 0,  0, 0, 0, 0,    0, 0));
      vecs.push_back(mk(1, 2, 2, 8,    0, 0, 0,  0, 0, 0, 0,    1, 1));
      vecs.push_back(mk(1, 3, 2, 8,    0, 0, 0,  0, 0, 0, 0,    1, 0));
      vecs.push_back(mk(0, 0, 0, 0,    1, 2, 1,  0, 1, 0, 7,    1, 0));
      vecs.push_back(mk(0, 0, 0, 0,    1, 2, 2,  0, 1, 0, 8,    1, 0));
      vecs.push_back(mk(1, 66, 1, 6,   0, 0, 0,  1, 0, 0, 8,    1, 0));
      vecs.push_back(mk(0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 8,    1, 0));
      for (int r = 0; r < 4; r++) begin
         for (int c = 1; c <= 2; c++) begin
            vecs.push_back(mk(0, 0, 0, 0, 1, r, c, 0, 1, 0, r_exp[r][c-1], 1, 0));
         end
      end
      vecs.push_back(mk(0, 0, 0, 0,    1, 66, 1, 0, 1, 1, 0,    1, 0));
      vecs.push_back(mk(1, 0, 3, 1,    1, 3, 3,  1, 1, 1, 0,    1, 0));
      vecs.push_back(mk(0, 0, 0, 0,    1, 4, 1,  0, 1, 1, 0,    1, 0));
      vecs.push_back(mk(0, 0, 0, 0,    1, 0, 0,  0, 1, 1, 0,    1, 0));
      vecs.push_back(mk(1, 3, 2, 0,    0, 0, 0,  0, 0, 0, 0,    1, 0));
      vecs.push_back(mk(1, 2, 2, 9,    0, 0, 0,  0, 0, 0, 0,    1, 0));
      vecs.push_back(mk(1, 2, 2, 0,    0, 0, 0,  0, 0, 0, 0,    2, 1));
      vecs.push_back(mk(1, 1, 1, 5,    0, 0, 0,  0, 0, 0, 0,    2, 0));
      vecs.push_back(mk(1, 1, 1, 'hAA, 1, 1, 1,  0, 1, 0, 5,    2, 0));
      vecs.push_back(mk(0, 0, 0, 0,    1, 1, 1,  0, 1, 0, 'hAA, 2, 0));
      vecs.push_back(mk(1, 2, 2, 0,    0, 0, 0,  0, 0, 0, 'hAA, 2, 0));
      vecs.push_back(mk(1, 2, 2, 7,    1, 2, 2,  0, 1, 0, 0,    2, 0));
      vecs.push_back(mk(1, 0, 1, 3,    1, 2, 1,  0, 1, 0, 7,    2, 0));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d wr_oob", i), 32'(wr_oob), 32'(vecs[i].x_wr_oob));
         checkOutput($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].x_rd_valid));
         checkOutput($sformatf("v%0d rd_oob", i), 32'(rd_oob), 32'(vecs[i].x_rd_oob));
         checkOutput($sformatf("v%0d rd_data", i), 32'(rd_data), 32'(vecs[i].x_rd_data));
         checkOutput($sformatf("v%0d watch_cnt", i), 32'(watch_cnt), 32'(vecs[i].x_cnt));
         checkOutput($sformatf("v%0d watch_pulse", i), 32'(watch_pulse), 32'(vecs[i].x_pulse));
         checkOutput($sformatf("v%0d sat_cnt", i), 32'(s_watch_cnt),
                     32'((vecs[i].x_cnt > 3) ? 3 : vecs[i].x_cnt));
      end

      // Retargeting the watch alone must not count.
      idleInputs();
      watch_bit = 3'd0;
      tick();
      checkOutput("retarget cnt", 32'(watch_cnt), 32'd2);
      checkOutput("retarget pulse", 32'(watch_pulse), 32'd0);

      // Out-of-range watch row whose naive flat address aliases [0][1].
      watch_row = 8'd4; watch_col = 8'd1;
      wr_en = 1'b1; wr_row = 8'd0; wr_col = 8'd1; wr_data = 8'd2;
      tick();
      checkOutput("oob watch cnt", 32'(watch_cnt), 32'd2);
      checkOutput("oob watch pulse", 32'(watch_pulse), 32'd0);

      // Saturation on the CNT_W=2 instance; [2][2] holds 0x07 (bit 3 clear).
      idleInputs();
      watch_row = 8'd2; watch_col = 8'd2; watch_bit = 3'd3;
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      checkOutput("clr cnt", 32'(watch_cnt), 32'd0);
      checkOutput("clr sat cnt", 32'(s_watch_cnt), 32'd0);
      sat_pulses = 0;
      for (int k = 1; k <= 5; k++) begin
         wr_en = 1'b1; wr_row = 8'd2; wr_col = 8'd2;
         wr_data = (k % 2 == 1) ? 8'h0F : 8'h07;
         tick();
         if (s_watch_pulse) sat_pulses++;
         checkOutput($sformatf("sat%0d cnt", k), 32'(s_watch_cnt), 32'((k > 3) ? 3 : k));
         checkOutput($sformatf("sat%0d main cnt", k), 32'(watch_cnt), 32'(k));
      end
      checkOutput("sat pulse count", 32'(sat_pulses), 32'd5);
      wr_data = 8'h07; cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
      checkOutput("clr+toggle sat cnt", 32'(s_watch_cnt), 32'd0);
      checkOutput("clr+toggle sat pulse", 32'(s_watch_pulse), 32'd1);
      checkOutput("clr+toggle main cnt", 32'(watch_cnt), 32'd0);
      checkOutput("clr+toggle main pulse", 32'(watch_pulse), 32'd1);

      // Mid-cycle asynchronous reset after a counted write and a read.
      wr_en = 1'b1; wr_row = 8'd2; wr_col = 8'd2; wr_data = 8'h0F;
      rd_en = 1'b1; rd_row = 8'd1; rd_col = 8'd1;
      tick();
      checkOutput("pre-reset rd_data", 32'(rd_data), 32'hAA);
      checkOutput("pre-reset pulse", 32'(watch_pulse), 32'd1);
      checkOutput("pre-reset cnt", 32'(watch_cnt), 32'd1);
      idleInputs();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async rd_data", 32'(rd_data), 32'd0);
      checkOutput("async rd_valid", 32'(rd_valid), 32'd0);
      checkOutput("async pulse", 32'(watch_pulse), 32'd0);
      checkOutput("async cnt", 32'(watch_cnt), 32'd0);
      checkOutput("async wr_oob", 32'(wr_oob), 32'd0);
      checkOutput("async rd_oob", 32'(rd_oob), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int c = 1; c <= 2; c++) begin
            readCheck($sformatf("post-reset [%0d][%0d]", r, c), r, c, 0, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
